// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light sequencer driven by a 1-second tick stream.
// Counts ticks per phase and supports a flashing-yellow maintenance mode.
module traffic_light_ctrl #(
  parameter int T_GREEN  = 5,
  parameter int T_YELLOW = 2,
  parameter int T_ALLRED = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             enable,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] sec_left,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    AR_A  = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR_B  = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] L_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] L_ALLRED = CNT_W'(T_ALLRED - 1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             flash_on, flash_n;
  logic [2:0]       ns_n, ew_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= AR_A;
      cnt      <= L_ALLRED;
      flash_on <= 1'b0;
      ns_light <= RED;
      ew_light <= RED;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      flash_on <= flash_n;
      ns_light <= ns_n;
      ew_light <= ew_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    flash_n = flash_on;
    case (state)
      FLASH: begin
        cnt_n = '0;
        if (enable) begin
          state_n = AR_A;
          cnt_n   = L_ALLRED;
          flash_n = 1'b0;
        end else if (tick) begin
          flash_n = ~flash_on;
        end
      end
      AR_A, NS_G, NS_Y, AR_B, EW_G, EW_Y: begin
        if (!enable) begin
          // Maintenance request wins over a tick arriving in the same cycle.
          state_n = FLASH;
          cnt_n   = '0;
          flash_n = 1'b1;
        end else if (tick) begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else begin
            case (state)
              AR_A:    begin state_n = NS_G; cnt_n = L_GREEN;  end
              NS_G:    begin state_n = NS_Y; cnt_n = L_YELLOW; end
              NS_Y:    begin state_n = AR_B; cnt_n = L_ALLRED; end
              AR_B:    begin state_n = EW_G; cnt_n = L_GREEN;  end
              EW_G:    begin state_n = EW_Y; cnt_n = L_YELLOW; end
              default: begin state_n = AR_A; cnt_n = L_ALLRED; end
            endcase
          end
        end
      end
      default: begin
        state_n = AR_A;
        cnt_n   = L_ALLRED;
        flash_n = 1'b0;
      end
    endcase
  end

  // Lamps are decoded from the next state so they register alongside it.
  always_comb begin
    ns_n = RED;
    ew_n = RED;
    case (state_n)
      NS_G:    ns_n = GRN;
      NS_Y:    ns_n = YEL;
      EW_G:    ew_n = GRN;
      EW_Y:    ew_n = YEL;
      FLASH: begin
        ns_n = flash_n ? YEL : OFF;
        ew_n = flash_n ? YEL : OFF;
      end
      default: begin
        ns_n = RED;
        ew_n = RED;
      end
    endcase
  end

  assign sec_left = cnt;
  assign phase    = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: phase-table model checked every cycle,
// plus directed literal checks of the sequencing, flash and reset behaviour.
module tb_traffic_light_ctrl;

  localparam int T_GREEN  = 5;
  localparam int T_YELLOW = 2;
  localparam int T_ALLRED = 1;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick = 1'b0;
  logic             enable = 1'b1;
  logic [2:0]       ns_light, ew_light;
  logic [CNT_W-1:0] sec_left;
  logic [2:0]       phase;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_light_ctrl #(
    .T_GREEN(T_GREEN), .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable),
    .ns_light(ns_light), .ew_light(ew_light), .sec_left(sec_left), .phase(phase)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model: phase table, durations and lamp patterns indexed by phase number
  int         dur    [6] = '{T_ALLRED, T_GREEN, T_YELLOW, T_ALLRED, T_GREEN, T_YELLOW};
  logic [2:0] ns_tab [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
  int m_phase = 0;
  int m_left  = 0;
  bit m_flash = 1'b0;
  bit m_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit onehot0(input logic [2:0] v);
    return (v == 3'b000) || (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // scoreboard: advance the model on each edge, compare after it settles
  always @(posedge clk) begin
    logic [2:0] e_ns, e_ew;
    if (!rst_n) begin
      m_phase = 0; m_left = T_ALLRED - 1; m_flash = 1'b0; m_valid = 1'b1;
    end else if (m_phase == 6) begin
      if (enable) begin
        m_phase = 0; m_left = dur[0] - 1; m_flash = 1'b0;
      end else if (tick) begin
        m_flash = !m_flash;
      end
    end else if (!enable) begin
      m_phase = 6; m_left = 0; m_flash = 1'b1;
    end else if (tick) begin
      if (m_left > 0) m_left--;
      else begin
        m_phase = (m_phase + 1) % 6;
        m_left  = dur[m_phase] - 1;
      end
    end
    #1;
    if (m_valid) begin
      e_ns = (m_phase == 6) ? (m_flash ? 3'b010 : 3'b000) : ns_tab[m_phase];
      e_ew = (m_phase == 6) ? (m_flash ? 3'b010 : 3'b000) : ew_tab[m_phase];
      check("model_phase", int'(phase), m_phase);
      check("model_sec_left", int'(sec_left), m_left);
      check("model_ns", int'(ns_light), int'(e_ns));
      check("model_ew", int'(ew_light), int'(e_ew));
      n_checks++;
      if (!onehot0(ns_light) || !onehot0(ew_light) ||
          (phase != 3'd6 && ns_light[1:0] != 2'b00 && ew_light[1:0] != 2'b00)) begin
        n_fail++;
        $display("FAIL safety: ns=%b ew=%b phase=%0d at %0t", ns_light, ew_light, phase, $time);
      end
    end
  end

  // driver: apply inputs on the falling edge, return after the next rising edge settles
  task automatic cyc(input logic t, input logic e, input logic r = 1'b1);
    @(negedge clk);
    tick = t; enable = e; rst_n = r;
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_tick(input int gap);
    cyc(1'b1, 1'b1);
    for (int i = 0; i < gap; i++) cyc(1'b0, 1'b1);
  endtask

  int exp_phase [16] = '{1, 1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 4, 5, 5, 0};
  int exp_left  [16] = '{4, 3, 2, 1, 0, 1, 0, 0, 4, 3, 2, 1, 0, 1, 0, 0};

  initial begin
    // reset
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("rst_phase", int'(phase), 0);
    check("rst_sec_left", int'(sec_left), 0);
    check("rst_ns", int'(ns_light), 3'b100);
    check("rst_ew", int'(ew_light), 3'b100);

    // 1: full cycle, tick every 10 clocks
    cyc(1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      pulse_tick(0);
      check("seq_phase", int'(phase), exp_phase[k]);
      check("seq_sec_left", int'(sec_left), exp_left[k]);
      for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1);
      check("seq_hold", int'(sec_left), exp_left[k]);
    end

    // 2: tick held three cycles in NS_G
    pulse_tick(2);
    check("ng_entry", int'(sec_left), 4);
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
    check("held_tick_sec", int'(sec_left), 1);
    check("held_tick_phase", int'(phase), 1);
    cyc(1'b0, 1'b1);

    // 3: walk to EW_G, then drop enable together with a tick
    for (int i = 0; i < 5; i++) pulse_tick(1);
    check("at_ew_g", int'(phase), 4);
    check("ew_g_lamp", int'(ew_light), 3'b001);
    cyc(1'b1, 1'b0);
    check("flash_phase", int'(phase), 6);
    check("flash_ns", int'(ns_light), 3'b010);
    check("flash_ew", int'(ew_light), 3'b010);
    check("flash_sec", int'(sec_left), 0);
    cyc(1'b1, 1'b0);
    check("flash_off_ns", int'(ns_light), 3'b000);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("flash_on_ew", int'(ew_light), 3'b010);

    // 4: leave FLASH with a simultaneous tick
    cyc(1'b1, 1'b1);
    check("exit_phase", int'(phase), 0);
    check("exit_sec", int'(sec_left), 0);
    check("exit_ns", int'(ns_light), 3'b100);
    cyc(1'b0, 1'b1);
    check("exit_tick_ignored", int'(phase), 0);

    // 5: reset during NS_Y with sec_left=1, tick ignored during reset
    for (int i = 0; i < 6; i++) pulse_tick(1);
    check("pre_rst_phase", int'(phase), 2);
    check("pre_rst_sec", int'(sec_left), 1);
    cyc(1'b1, 1'b1, 1'b0);
    check("mid_rst_phase", int'(phase), 0);
    check("mid_rst_sec", int'(sec_left), 0);
    check("mid_rst_ew", int'(ew_light), 3'b100);
    cyc(1'b1, 1'b1);
    check("post_rst_phase", int'(phase), 1);
    check("post_rst_sec", int'(sec_left), 4);

    // 6: random tick/enable with rare resets
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) != 0),
          ($urandom_range(0, 499) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
